vsim_send_arbiter: RTL and testbench

- Shares one simulation message sink between NUM_REQ requesters; the sink is a DPI send endpoint with a PipeInLast-style enq/last interface.
- Arbitrates round-robin at message granularity: once granted, a requester owns the sink until it sends its beat with last=1.
- A one-entry registered output stage decouples requester timing from sink readiness.
- Sits between multiple simulation-side producers (indication proxies) and the single send endpoint.

---
 rtl/vsim_send_arbiter.sv | 178 +++++++++++++++++
 tb/tb_vsim_send_arbiter.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsim_send_arbiter.sv
// vsim_send_arbiter: message-granular round-robin arbiter that lets NUM_REQ
// producers share one enq/last send endpoint. A granted requester keeps the
// sink until its last beat is accepted. A one-entry registered output stage
// sits between the winner and the sink.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no owner; pick the next requester round-robin from rr_ptr
// LOCKED | owner_q holds the sink until it delivers a beat with last=1
module vsim_send_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int width   = 32,
    parameter int CNT_W   = 16,
    localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       in_req,
    input  logic [NUM_REQ-1:0]       in_enq__ENA,
    input  logic [NUM_REQ*width-1:0] in_enq_v,
    input  logic [NUM_REQ-1:0]       in_enq_last,
    output logic [NUM_REQ-1:0]       in_enq__RDY,
    output logic                     out_enq__ENA,
    output logic [width-1:0]         out_enq_v,
    output logic                     out_enq_last,
    input  logic                     out_enq__RDY,
    output logic                     grant_valid,
    output logic [ID_W-1:0]          grant_id,
    output logic [CNT_W-1:0]         msg_count,
    output logic [CNT_W-1:0]         beat_count,
    output logic                     proto_err
);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic             full_q, full_d;
    logic [width-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             err_q, err_d;

    logic             space;
    logic             accept;
    logic             violation;
    logic             found;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  owner_next;
    logic [width-1:0] beat_v;
    logic             beat_last;
    int               scan_idx;

    // The stage can take a beat when empty or when its current beat leaves this cycle.
    assign space        = !full_q || out_enq__RDY;
    assign out_enq__ENA = full_q && out_enq__RDY;
    assign out_enq_v    = data_q;
    assign out_enq_last = last_q;

    assign grant_valid = (state_q == S_LOCKED);
    assign grant_id    = owner_q;
    assign msg_count   = msg_cnt_q;
    assign beat_count  = beat_cnt_q;
    assign proto_err   = err_q;

    // Only the owner sees ready, and only while the output stage has room.
    always_comb begin
        in_enq__RDY = '0;
        if (state_q == S_LOCKED) begin
            in_enq__RDY[owner_q] = space;
        end
    end

    // Any enable without a matching ready is a violation; such beats never count as accepted.
    assign accept    = |(in_enq__ENA & in_enq__RDY);
    assign violation = |(in_enq__ENA & ~in_enq__RDY);
    assign beat_v    = in_enq_v[int'(owner_q)*width +: width];
    assign beat_last = in_enq_last[owner_q];

    assign owner_next = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    // Round-robin search: first pending requester at or above rr_ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && in_req[scan_idx]) begin
                found  = 1'b1;
                winner = ID_W'(scan_idx);
            end
        end
    end

    // Next-state for grant FSM, output stage, counters and error flag.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        full_d     = full_q;
        data_d     = data_q;
        last_d     = last_q;
        msg_cnt_d  = msg_cnt_q;
        beat_cnt_d = beat_cnt_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d = S_LOCKED;
                    owner_d = winner;
                end
            end
            S_LOCKED: begin
                // Release only on an accepted last beat; in_req is ignored here.
                if (accept && beat_last) begin
                    state_d  = S_IDLE;
                    rr_ptr_d = owner_next;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            full_d = 1'b1;
            data_d = beat_v;
            last_d = beat_last;
        end else if (out_enq__ENA) begin
            full_d = 1'b0;
        end

        if (out_enq__ENA) begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
            if (last_q) begin
                msg_cnt_d = msg_cnt_q + CNT_W'(1);
            end
        end

        if (violation) begin
            err_d = 1'b1;
        end
    end

    // State register; reset also discards any beat held in the output stage.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            full_q     <= 1'b0;
            data_q     <= '0;
            last_q     <= 1'b0;
            msg_cnt_q  <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            full_q     <= full_d;
            data_q     <= data_d;
            last_q     <= last_d;
            msg_cnt_q  <= msg_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_vsim_send_arbiter.sv
// Bench for vsim_send_arbiter: per-requester beat queues feed the DUT, a
// sampler logs sink beats and grant events, and each test compares the logs
// against expectations derived from the arbitration rules.
module tb_vsim_send_arbiter;
    localparam int NR = 4;
    localparam int W  = 32;
    localparam int CW = 16;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NR-1:0]   in_req;
    logic [NR-1:0]   in_enq__ENA;
    logic [NR*W-1:0] in_enq_v;
    logic [NR-1:0]   in_enq_last;
    logic [NR-1:0]   in_enq__RDY;
    logic            out_enq__ENA;
    logic [W-1:0]    out_enq_v;
    logic            out_enq_last;
    logic            out_enq__RDY;
    logic            grant_valid;
    logic [1:0]      grant_id;
    logic [CW-1:0]   msg_count;
    logic [CW-1:0]   beat_count;
    logic            proto_err;

    int checks = 0;
    int errors = 0;

    logic [W:0]    pmem [NR][64];
    int            phead [NR];
    int            ptail [NR];
    int            rdy_mode = 0;
    int            err_req = 0;
    int            err_done = 0;
    int            cyc = 0;
    int            exp_beats = 0;
    int            exp_msgs = 0;
    int            model_rr = 0;

    logic [W-1:0]  sink_d [$];
    logic          sink_l [$];
    int            sink_c [$];
    int            gnt_id [$];
    logic [NR-1:0] gnt_req [$];
    int            gnt_c [$];

    vsim_send_arbiter #(.NUM_REQ(NR), .width(W), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .in_req(in_req), .in_enq__ENA(in_enq__ENA),
        .in_enq_v(in_enq_v), .in_enq_last(in_enq_last), .in_enq__RDY(in_enq__RDY),
        .out_enq__ENA(out_enq__ENA), .out_enq_v(out_enq_v), .out_enq_last(out_enq_last),
        .out_enq__RDY(out_enq__RDY), .grant_valid(grant_valid), .grant_id(grant_id),
        .msg_count(msg_count), .beat_count(beat_count), .proto_err(proto_err)
    );

    always #5 CLK = ~CLK;

    // Producers and sink: drive at negedge, sample just before the next posedge.
    initial begin : driver
        logic [NR-1:0] req_prev;
        logic          gv_prev;
        logic          rst_prev;
        in_req = '0; in_enq__ENA = '0; in_enq_v = '0; in_enq_last = '0; out_enq__RDY = 1'b0;
        req_prev = '0; gv_prev = 1'b0; rst_prev = 1'b1;
        forever begin
            @(negedge CLK);
            case (rdy_mode)
                0:       out_enq__RDY = 1'b1;
                1:       out_enq__RDY = ($urandom_range(0, 9) < 7);
                default: out_enq__RDY = 1'b0;
            endcase
            #1;
            in_enq__ENA = '0; in_enq_v = '0; in_enq_last = '0;
            for (int i = 0; i < NR; i++) begin
                in_req[i] = (phead[i] < ptail[i]);
                if (in_req[i] && in_enq__RDY[i]) begin
                    in_enq__ENA[i]      = 1'b1;
                    in_enq_v[i*W +: W]  = pmem[i][phead[i]][W-1:0];
                    in_enq_last[i]      = pmem[i][phead[i]][W];
                    phead[i]++;
                end
            end
            if (err_req != err_done) begin
                in_enq__ENA[3]     = 1'b1;
                in_enq_v[3*W +: W] = 32'hDEAD;
                err_done++;
            end
            #3;
            if (out_enq__ENA) begin
                sink_d.push_back(out_enq_v);
                sink_l.push_back(out_enq_last);
                sink_c.push_back(cyc);
            end
            if (grant_valid && !gv_prev && !rst_prev) begin
                gnt_id.push_back(int'(grant_id));
                gnt_req.push_back(req_prev);
                gnt_c.push_back(cyc);
            end
            req_prev = in_req; gv_prev = grant_valid; rst_prev = RST;
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    function automatic int exp_winner(logic [NR-1:0] req, int rr);
        for (int k = 0; k < NR; k++) if (req[(rr + k) % NR]) return (rr + k) % NR;
        return -1;
    endfunction

    task automatic load(int id, logic [W-1:0] d, logic l);
        pmem[id][ptail[id]] = {l, d};
        ptail[id]++;
    endtask

    task automatic clear_logs();
        sink_d.delete(); sink_l.delete(); sink_c.delete();
        gnt_id.delete(); gnt_req.delete(); gnt_c.delete();
    endtask

    task automatic clear_queues();
        for (int i = 0; i < NR; i++) begin phead[i] = 0; ptail[i] = 0; end
        exp_beats = 0; exp_msgs = 0; model_rr = 0;
    endtask

    task automatic wait_sink(int n, int bound);
        for (int t = 0; t < bound && sink_d.size() < n; t++) begin @(posedge CLK); #2; end
    endtask

    task automatic do_reset();
        @(posedge CLK); #2; RST = 1'b1;
        @(posedge CLK); #2; RST = 1'b0;
        clear_queues();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge CLK);
        #2;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL reset_gv got %0b want 0", grant_valid); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_gid got %0d want 0", grant_id); end
        checks++; if (msg_count !== 16'd0) begin errors++; $display("FAIL reset_msg got %0d want 0", msg_count); end
        checks++; if (beat_count !== 16'd0) begin errors++; $display("FAIL reset_beat got %0d want 0", beat_count); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %0b want 0", proto_err); end
        checks++; if (in_enq__RDY !== 4'b0) begin errors++; $display("FAIL reset_rdy got %b want 0000", in_enq__RDY); end
        @(negedge CLK); #2;
        checks++; if (out_enq__ENA !== 1'b0) begin errors++; $display("FAIL reset_oena got %0b want 0", out_enq__ENA); end
        @(posedge CLK); #2; RST = 1'b0;
        repeat (3) @(posedge CLK);
        #2;
        checks++; if (grant_valid !== 1'b0) begin errors++; $display("FAIL idle_nogrant got %0b want 0", grant_valid); end
    endtask

    task automatic test_all_rr();
        clear_logs(); rdy_mode = 0;
        @(posedge CLK); #2;
        for (int m = 0; m < 2; m++)
            for (int i = 0; i < NR; i++) load(i, {4'(i), 28'(m)}, 1'b1);
        wait_sink(8, 100);
        checks++; if (sink_d.size() != 8) begin errors++; $display("FAIL rr_count got %0d want 8", sink_d.size()); end
        for (int k = 0; k < sink_d.size(); k++) begin
            checks++;
            if (int'(sink_d[k][31:28]) != (model_rr + k) % NR || sink_l[k] !== 1'b1) begin
                errors++; $display("FAIL rr_order[%0d] got id %0d last %0b want id %0d last 1", k, sink_d[k][31:28], sink_l[k], (model_rr + k) % NR);
            end
        end
        for (int k = 1; k < gnt_c.size(); k++) begin
            checks++;
            if (gnt_c[k] - gnt_c[k-1] != 2) begin errors++; $display("FAIL rr_gap[%0d] got %0d want 2", k, gnt_c[k] - gnt_c[k-1]); end
        end
        exp_beats += 8; exp_msgs += 8;
        checks++; if (int'(beat_count) != exp_beats) begin errors++; $display("FAIL rr_beats got %0d want %0d", beat_count, exp_beats); end
        checks++; if (int'(msg_count) != exp_msgs) begin errors++; $display("FAIL rr_msgs got %0d want %0d", msg_count, exp_msgs); end
    endtask

    task automatic test_single();
        int l_cyc;
        do_reset(); clear_logs(); rdy_mode = 0;
        load(2, 32'hA1, 1'b0); load(2, 32'hA2, 1'b0); load(2, 32'hA3, 1'b1);
        l_cyc = cyc;
        wait_sink(3, 50);
        repeat (3) @(posedge CLK);
        #2;
        checks++; if (sink_d.size() != 3) begin errors++; $display("FAIL single_count got %0d want 3", sink_d.size()); end
        for (int k = 0; k < 3 && k < sink_d.size(); k++) begin
            checks++;
            if (sink_d[k] !== 32'hA1 + 32'(k) || sink_l[k] !== (k == 2)) begin
                errors++; $display("FAIL single_beat[%0d] got %h/%0b want %h/%0b", k, sink_d[k], sink_l[k], 32'hA1 + 32'(k), (k == 2));
            end
        end
        checks++; if (gnt_id.size() != 1 || gnt_id[0] != 2) begin errors++; $display("FAIL single_gid got %0d grants want one grant of 2", gnt_id.size()); end
        checks++; if (sink_c.size() < 1 || sink_c[0] != l_cyc + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", sink_c.size() > 0 ? sink_c[0] : -1, l_cyc + 2); end
        checks++; if (msg_count !== 16'd1 || beat_count !== 16'd3) begin errors++; $display("FAIL single_cnt got %0d/%0d want 1/3", msg_count, beat_count); end
        checks++; if (proto_err !== 1'b0 || grant_valid !== 1'b0) begin errors++; $display("FAIL single_end got perr %0b gv %0b want 0 0", proto_err, grant_valid); end
        exp_beats = 3; exp_msgs = 1; model_rr = 3;
    endtask

    task automatic test_hold_off();
        logic [W-1:0] hv [6];
        hv = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h01, 32'h02};
        clear_logs(); rdy_mode = 0;
        @(posedge CLK); #2;
        for (int b = 0; b < 4; b++) load(1, 32'h11 + 32'(b), b == 3);
        for (int t = 0; t < 50 && gnt_id.size() < 1; t++) begin @(posedge CLK); #2; end
        load(0, 32'h01, 1'b0); load(0, 32'h02, 1'b1);
        wait_sink(6, 100);
        checks++; if (sink_d.size() != 6) begin errors++; $display("FAIL hold_count got %0d want 6", sink_d.size()); end
        for (int k = 0; k < 6 && k < sink_d.size(); k++) begin
            checks++;
            if (sink_d[k] !== hv[k] || sink_l[k] !== (k == 3 || k == 5)) begin
                errors++; $display("FAIL hold_beat[%0d] got %h/%0b want %h/%0b", k, sink_d[k], sink_l[k], hv[k], (k == 3 || k == 5));
            end
        end
        checks++; if (gnt_id.size() != 2 || gnt_id[0] != 1 || gnt_id[1] != 0) begin errors++; $display("FAIL hold_grants got %0d grants want 1 then 0", gnt_id.size()); end
        exp_beats += 6; exp_msgs += 2; model_rr = 1;
    endtask

    task automatic test_stall();
        clear_logs(); rdy_mode = 0;
        @(posedge CLK); #2;
        for (int b = 0; b < 6; b++) load(2, 32'h21 + 32'(b), b == 5);
        wait_sink(2, 50);
        rdy_mode = 2;
        for (int s = 0; s < 5; s++) begin
            @(negedge CLK); #2;
            checks++;
            if (out_enq__ENA !== 1'b0 || in_enq__RDY !== 4'b0 || out_enq_v !== 32'h23 || out_enq_last !== 1'b0) begin
                errors++; $display("FAIL stall_hold[%0d] got ena %0b rdy %b v %h want 0 0000 00000023", s, out_enq__ENA, in_enq__RDY, out_enq_v);
            end
        end
        rdy_mode = 0;
        wait_sink(6, 50);
        repeat (4) @(posedge CLK);
        #2;
        checks++; if (sink_d.size() != 6) begin errors++; $display("FAIL stall_count got %0d want 6", sink_d.size()); end
        for (int k = 0; k < 6 && k < sink_d.size(); k++) begin
            checks++;
            if (sink_d[k] !== 32'h21 + 32'(k) || sink_l[k] !== (k == 5)) begin
                errors++; $display("FAIL stall_beat[%0d] got %h/%0b want %h/%0b", k, sink_d[k], sink_l[k], 32'h21 + 32'(k), (k == 5));
            end
        end
        exp_beats += 6; exp_msgs += 1; model_rr = 3;
    endtask

    task automatic test_proto_err();
        clear_logs(); rdy_mode = 0;
        @(posedge CLK); #2;
        err_req++;
        repeat (2) @(posedge CLK);
        #2;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set got %0b want 1", proto_err); end
        repeat (5) @(posedge CLK);
        #2;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky got %0b want 1", proto_err); end
        checks++; if (sink_d.size() != 0 || grant_valid !== 1'b0) begin errors++; $display("FAIL perr_leak got %0d beats gv %0b want 0 0", sink_d.size(), grant_valid); end
        checks++; if (int'(beat_count) != exp_beats || int'(msg_count) != exp_msgs) begin errors++; $display("FAIL perr_cnt got %0d/%0d want %0d/%0d", beat_count, msg_count, exp_beats, exp_msgs); end
    endtask

    task automatic test_random();
        int st [NR];
        int ex [NR];
        int tot, nm, seq, cur, mi, rr, id;
        clear_logs(); rdy_mode = 1;
        @(posedge CLK); #2;
        tot = 0; nm = 0; seq = 0;
        for (int i = 0; i < NR; i++) begin
            st[i] = ptail[i];
            for (int m = 0; m < int'($urandom_range(2, 5)); m++) begin
                int len = int'($urandom_range(1, 4));
                for (int b = 0; b < len; b++) begin
                    load(i, {4'(i), 4'(0), 24'(seq)}, b == len - 1);
                    seq++; tot++;
                end
                nm++;
            end
        end
        wait_sink(tot, 3000);
        rdy_mode = 0;
        repeat (3) @(posedge CLK);
        #2;
        checks++; if (sink_d.size() != tot) begin errors++; $display("FAIL rand_count got %0d want %0d", sink_d.size(), tot); end
        for (int i = 0; i < NR; i++) ex[i] = st[i];
        cur = -1; mi = 0;
        for (int k = 0; k < sink_d.size(); k++) begin
            id = int'(sink_d[k][31:28]);
            checks++;
            if (id >= NR || (cur != -1 && id != cur) || (cur == -1 && (mi >= gnt_id.size() || gnt_id[mi] != id))) begin
                errors++; $display("FAIL rand_owner[%0d] got id %0d want owner %0d", k, id, cur);
            end else if ({sink_l[k], sink_d[k]} !== pmem[id][ex[id]]) begin
                errors++; $display("FAIL rand_beat[%0d] got %h/%0b want %h", k, sink_d[k], sink_l[k], pmem[id][ex[id]]);
            end
            if (id < NR) ex[id]++;
            if (cur == -1) mi++;
            cur = sink_l[k] ? -1 : id;
        end
        rr = model_rr;
        for (int k = 0; k < gnt_id.size(); k++) begin
            checks++;
            if (gnt_id[k] != exp_winner(gnt_req[k], rr)) begin
                errors++; $display("FAIL rand_grant[%0d] got %0d want %0d", k, gnt_id[k], exp_winner(gnt_req[k], rr));
            end
            rr = (gnt_id[k] + 1) % NR;
        end
        model_rr = rr;
        exp_beats += tot; exp_msgs += nm;
        checks++; if (int'(beat_count) != exp_beats || int'(msg_count) != exp_msgs) begin errors++; $display("FAIL rand_cnt got %0d/%0d want %0d/%0d", beat_count, msg_count, exp_beats, exp_msgs); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL rand_perr got %0b want 1", proto_err); end
    endtask

    task automatic test_reset_mid();
        clear_logs(); rdy_mode = 0;
        @(posedge CLK); #2;
        for (int b = 0; b < 4; b++) load(0, 32'hB0 + 32'(b), b == 3);
        for (int t = 0; t < 50 && sink_d.size() < 1; t++) begin @(posedge CLK); #2; end
        RST = 1'b1; rdy_mode = 2;
        @(posedge CLK); #2;
        clear_queues(); rdy_mode = 0;
        checks++; if (grant_valid !== 1'b0 || grant_id !== 2'd0) begin errors++; $display("FAIL rmid_grant got gv %0b id %0d want 0 0", grant_valid, grant_id); end
        checks++; if (msg_count !== 16'd0 || beat_count !== 16'd0) begin errors++; $display("FAIL rmid_cnt got %0d/%0d want 0/0", msg_count, beat_count); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rmid_perr got %0b want 0", proto_err); end
        @(negedge CLK); #2;
        checks++; if (out_enq__ENA !== 1'b0 || in_enq__RDY !== 4'b0) begin errors++; $display("FAIL rmid_stage got ena %0b rdy %b want 0 0000", out_enq__ENA, in_enq__RDY); end
        @(posedge CLK); #2; RST = 1'b0;
        clear_logs();
        repeat (3) @(posedge CLK);
        #2;
        checks++; if (sink_d.size() != 0) begin errors++; $display("FAIL rmid_tail got %0d beats want 0", sink_d.size()); end
        for (int b = 0; b < 4; b++) load(0, 32'hC0 + 32'(b), b == 3);
        wait_sink(4, 50);
        repeat (3) @(posedge CLK);
        #2;
        checks++; if (sink_d.size() != 4) begin errors++; $display("FAIL rmid_count got %0d want 4", sink_d.size()); end
        for (int k = 0; k < 4 && k < sink_d.size(); k++) begin
            checks++;
            if (sink_d[k] !== 32'hC0 + 32'(k) || sink_l[k] !== (k == 3)) begin
                errors++; $display("FAIL rmid_beat[%0d] got %h/%0b want %h/%0b", k, sink_d[k], sink_l[k], 32'hC0 + 32'(k), (k == 3));
            end
        end
        checks++; if (msg_count !== 16'd1 || beat_count !== 16'd4) begin errors++; $display("FAIL rmid_cnt2 got %0d/%0d want 1/4", msg_count, beat_count); end
    endtask

    initial begin
        test_reset();
        test_all_rr();
        test_single();
        test_hold_off();
        test_stall();
        test_proto_err();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
